cache_mem_arbiter: RTL

- Shares the single block-wide RAM port between I-cache refills and D-cache refills/writebacks.
- Sits between the cache pair and main memory, replacing direct cache-to-RAM wiring.
- Sequences one transfer at a time with an IDLE/BUSY/RESP FSM and round-robin tie-break.
- Provides per-requester ack pulses, a transfer watchdog and wrapping transfer counters.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_mem_arbiter_rr_pick2.sv | 23 ++
 rtl/cache_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/RAM arbiter slice.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } arb_state_e;

   localparam logic GNT_IC = 1'b0;
   localparam logic GNT_DC = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
module rr_pick2
   import cache_arb_pkg::*;
(
   input  logic ic_req_i,
   input  logic dc_req_i,
   input  logic last_grant_dc_i,
   output logic grant_dc_o,
   output logic valid_o
);

   // On a tie, the requester that did not win last time goes first.
   always_comb begin
      valid_o    = ic_req_i | dc_req_i;
      grant_dc_o = GNT_IC;
      if (ic_req_i && dc_req_i) begin
         grant_dc_o = (last_grant_dc_i == GNT_DC) ? GNT_IC : GNT_DC;
      end else if (dc_req_i) begin
         grant_dc_o = GNT_DC;
      end
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one block-wide RAM port between I-cache refills and D-cache
// refills/writebacks, one transfer at a time, with a watchdog and counters.
module cache_mem_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 30,
   parameter int DATA_WIDTH     = 32,
   parameter int OFFSET_WIDTH   = 3,
   parameter int BLOCK_WIDTH    = DATA_WIDTH << OFFSET_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ic_req,
   input  logic [ADDR_WIDTH-1:0]  ic_addr,
   output logic                   ic_ack,
   input  logic                   dc_req,
   input  logic                   dc_write,
   input  logic [ADDR_WIDTH-1:0]  dc_addr,
   input  logic [BLOCK_WIDTH-1:0] dc_wblock,
   output logic                   dc_ack,
   output logic [BLOCK_WIDTH-1:0] rd_block,
   output logic                   ram_en_out,
   output logic                   ram_write_out,
   output logic [ADDR_WIDTH-1:0]  ram_addr_out,
   output logic [BLOCK_WIDTH-1:0] ram_wblock_out,
   input  logic                   ram_ready,
   input  logic [BLOCK_WIDTH-1:0] block_from_ram,
   output logic                   busy,
   output logic                   grant_dc,
   output logic                   timeout_err,
   output logic [CNT_WIDTH-1:0]   ic_xfer_cnt,
   output logic [CNT_WIDTH-1:0]   dc_xfer_cnt
);

   localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

   arb_state_e             state_q, state_d;
   logic                   last_grant_dc_q, last_grant_dc_d;
   logic                   grant_dc_q, grant_dc_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   write_q, write_d;
   logic [BLOCK_WIDTH-1:0] wblock_q, wblock_d;
   logic [BLOCK_WIDTH-1:0] rd_block_q, rd_block_d;
   logic [WD_WIDTH-1:0]    wdog_q, wdog_d;
   logic                   timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0]   ic_cnt_q, ic_cnt_d;
   logic [CNT_WIDTH-1:0]   dc_cnt_q, dc_cnt_d;
   logic                   ic_ack_q, ic_ack_d;
   logic                   dc_ack_q, dc_ack_d;
   logic                   ram_en_q, ram_en_d;
   logic                   ram_write_q, ram_write_d;
   logic                   busy_q, busy_d;
   logic                   pick_dc, pick_valid;

   rr_pick2 u_pick (
      .ic_req_i       (ic_req),
      .dc_req_i       (dc_req),
      .last_grant_dc_i(last_grant_dc_q),
      .grant_dc_o     (pick_dc),
      .valid_o        (pick_valid)
   );

   always_comb begin
      state_d         = state_q;
      last_grant_dc_d = last_grant_dc_q;
      grant_dc_d      = grant_dc_q;
      addr_d          = addr_q;
      write_d         = write_q;
      wblock_d        = wblock_q;
      rd_block_d      = rd_block_q;
      wdog_d          = wdog_q;
      timeout_d       = timeout_q;
      ic_cnt_d        = ic_cnt_q;
      dc_cnt_d        = dc_cnt_q;
      ic_ack_d        = 1'b0;
      dc_ack_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d         = BUSY;
               grant_dc_d      = pick_dc;
               last_grant_dc_d = pick_dc;
               wdog_d          = WD_WIDTH'(1);
               if (pick_dc == GNT_DC) begin
                  addr_d   = dc_addr;
                  write_d  = dc_write;
                  wblock_d = dc_wblock;
               end else begin
                  addr_d   = ic_addr;
                  write_d  = 1'b0;
                  wblock_d = '0;
               end
            end
         end
         BUSY: begin
            // Counters and ack move together so the count is current when ack is seen.
            if (ram_ready) begin
               state_d = RESP;
               if (!write_q) begin
                  rd_block_d = block_from_ram;
               end
               if (grant_dc_q == GNT_DC) begin
                  dc_ack_d = 1'b1;
                  dc_cnt_d = dc_cnt_q + CNT_WIDTH'(1);
               end else begin
                  ic_ack_d = 1'b1;
                  ic_cnt_d = ic_cnt_q + CNT_WIDTH'(1);
               end
            end else if (wdog_q != WD_LIMIT) begin
               wdog_d = wdog_q + WD_WIDTH'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            wdog_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == BUSY) && (wdog_d == WD_LIMIT)) begin
         timeout_d = 1'b1;
      end
      ram_en_d    = (state_d == BUSY);
      ram_write_d = (state_d == BUSY) && write_d;
      busy_d      = (state_d != IDLE);
   end

   // last_grant_dc resets to the D-cache so the first tie favours the I-cache.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         last_grant_dc_q <= GNT_DC;
         grant_dc_q      <= GNT_IC;
         addr_q          <= '0;
         write_q         <= 1'b0;
         wblock_q        <= '0;
         rd_block_q      <= '0;
         wdog_q          <= '0;
         timeout_q       <= 1'b0;
         ic_cnt_q        <= '0;
         dc_cnt_q        <= '0;
         ic_ack_q        <= 1'b0;
         dc_ack_q        <= 1'b0;
         ram_en_q        <= 1'b0;
         ram_write_q     <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_dc_q <= last_grant_dc_d;
         grant_dc_q      <= grant_dc_d;
         addr_q          <= addr_d;
         write_q         <= write_d;
         wblock_q        <= wblock_d;
         rd_block_q      <= rd_block_d;
         wdog_q          <= wdog_d;
         timeout_q       <= timeout_d;
         ic_cnt_q        <= ic_cnt_d;
         dc_cnt_q        <= dc_cnt_d;
         ic_ack_q        <= ic_ack_d;
         dc_ack_q        <= dc_ack_d;
         ram_en_q        <= ram_en_d;
         ram_write_q     <= ram_write_d;
         busy_q          <= busy_d;
      end
   end

   assign ic_ack         = ic_ack_q;
   assign dc_ack         = dc_ack_q;
   assign rd_block       = rd_block_q;
   assign ram_en_out     = ram_en_q;
   assign ram_write_out  = ram_write_q;
   assign ram_addr_out   = addr_q;
   assign ram_wblock_out = wblock_q;
   assign busy           = busy_q;
   assign grant_dc       = grant_dc_q;
   assign timeout_err    = timeout_q;
   assign ic_xfer_cnt    = ic_cnt_q;
   assign dc_xfer_cnt    = dc_cnt_q;

endmodule
